// File: rtl/divisor_pkg.sv
// Shared constants, write-select encodings and width helper for the multichannel clock divider.
package divisor_pkg;

  localparam int unsigned ANCHO_DEF   = 26;
  localparam int unsigned DIV_DEF     = 4999;
  localparam int unsigned CANALES_MAX = 16;

  typedef enum logic {
    SEL_DIV  = 1'b0,
    SEL_DUTY = 1'b1
  } wr_sel_e;

  // Index width for n items, never below 1 so a single channel still has a select port.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/divisor_canal.sv
// One divider channel: counter, active/shadow divide value, clk_div level and tick.
// DIVISOR_DUTY_EN adds a shadowed duty register and compare-mode clk_div.
module divisor_canal #(
  parameter int unsigned ANCHO   = divisor_pkg::ANCHO_DEF,
  parameter int unsigned DIV_DEF = divisor_pkg::DIV_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             sync,
  input  logic             wr,
`ifdef DIVISOR_DUTY_EN
  input  logic             wr_sel,
`endif
  input  logic [ANCHO-1:0] wr_dato,
  output logic             clk_div,
  output logic             tick,
  output logic             pendiente
);

  import divisor_pkg::*;

  localparam logic [ANCHO-1:0] DIV_RST = ANCHO'(DIV_DEF);

  logic [ANCHO-1:0] cnt, cnt_n;
  logic [ANCHO-1:0] div, div_n;
  logic [ANCHO-1:0] shadow, shadow_n;
  logic             clk_div_n, tick_n, pendiente_n;

`ifdef DIVISOR_DUTY_EN
  localparam logic [ANCHO-1:0] DUTY_RST = ANCHO'((DIV_DEF + 1) / 2);

  logic [ANCHO-1:0] duty, duty_n;
  logic [ANCHO-1:0] duty_sh, duty_sh_n;
`endif

  // Next state: sync beats wrap beats enable; a write lands in the shadow after any apply.
  always_comb begin
    cnt_n       = cnt;
    div_n       = div;
    shadow_n    = shadow;
    clk_div_n   = clk_div;
    tick_n      = 1'b0;
    pendiente_n = pendiente;
`ifdef DIVISOR_DUTY_EN
    duty_n      = duty;
    duty_sh_n   = duty_sh;
`endif

    if (sync) begin
      cnt_n       = '0;
      clk_div_n   = 1'b0;
      div_n       = shadow;
      pendiente_n = 1'b0;
`ifdef DIVISOR_DUTY_EN
      duty_n      = duty_sh;
`endif
    end else if (en) begin
      if (cnt == div) begin
        cnt_n       = '0;
        tick_n      = 1'b1;
        div_n       = shadow;
        pendiente_n = 1'b0;
`ifdef DIVISOR_DUTY_EN
        duty_n      = duty_sh;
`else
        clk_div_n   = ~clk_div;
`endif
      end else begin
        cnt_n = cnt + ANCHO'(1);
      end
`ifdef DIVISOR_DUTY_EN
      clk_div_n = (cnt_n < duty_n);
`endif
    end

    if (wr) begin
`ifdef DIVISOR_DUTY_EN
      if (wr_sel == SEL_DUTY) duty_sh_n = wr_dato;
      else                    shadow_n  = wr_dato;
`else
      shadow_n = wr_dato;
`endif
      pendiente_n = 1'b1;
    end
  end

  // Channel state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt       <= '0;
      div       <= DIV_RST;
      shadow    <= DIV_RST;
      clk_div   <= 1'b0;
      tick      <= 1'b0;
      pendiente <= 1'b0;
    end else begin
      cnt       <= cnt_n;
      div       <= div_n;
      shadow    <= shadow_n;
      clk_div   <= clk_div_n;
      tick      <= tick_n;
      pendiente <= pendiente_n;
    end
  end

`ifdef DIVISOR_DUTY_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      duty    <= DUTY_RST;
      duty_sh <= DUTY_RST;
    end else begin
      duty    <= duty_n;
      duty_sh <= duty_sh_n;
    end
  end
`endif

endmodule

// File: rtl/divisor_reloj_multicanal.sv
// CANALES independent programmable clock dividers with shared sync and write port.
// Optional DIVISOR_DUTY_EN adds wr_sel and per-channel duty control.
module divisor_reloj_multicanal #(
  parameter  int unsigned CANALES = 4,
  parameter  int unsigned ANCHO   = divisor_pkg::ANCHO_DEF,
  parameter  int unsigned DIV_DEF = divisor_pkg::DIV_DEF,
  localparam int unsigned CW      = divisor_pkg::clog2(CANALES)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [CANALES-1:0] en,
  input  logic               sync,
  input  logic               wr_en,
`ifdef DIVISOR_DUTY_EN
  input  logic               wr_sel,
`endif
  input  logic [CW-1:0]      wr_canal,
  input  logic [ANCHO-1:0]   wr_dato,
  output logic [CANALES-1:0] clk_div,
  output logic [CANALES-1:0] tick,
  output logic [CANALES-1:0] pendiente
);

  import divisor_pkg::*;

  // Exact-match decode: out-of-range channel numbers select nothing.
  for (genvar i = 0; i < CANALES; i++) begin : g_canal
    logic wr_hit;

    assign wr_hit = wr_en && (wr_canal == CW'(i));

    divisor_canal #(
      .ANCHO   (ANCHO),
      .DIV_DEF (DIV_DEF)
    ) u_canal (
      .clk       (clk),
      .reset_n   (reset_n),
      .en        (en[i]),
      .sync      (sync),
      .wr        (wr_hit),
`ifdef DIVISOR_DUTY_EN
      .wr_sel    (wr_sel),
`endif
      .wr_dato   (wr_dato),
      .clk_div   (clk_div[i]),
      .tick      (tick[i]),
      .pendiente (pendiente[i])
    );
  end

endmodule

// File: tb/tb_divisor_reloj_multicanal.sv
// Directed bench for divisor_reloj_multicanal: 3 channels, 8-bit counters, reset divide value 4.
module tb_divisor_reloj_multicanal;

  localparam int unsigned CANALES = 3;
  localparam int unsigned ANCHO   = 8;
  localparam int unsigned DIV_DEF = 4;

  logic               clk = 1'b0;
  logic               reset_n = 1'b1;
  logic [CANALES-1:0] en = '1;
  logic               sync = 1'b0;
  logic               wr_en = 1'b0;
`ifdef DIVISOR_DUTY_EN
  logic               wr_sel = 1'b0;
`endif
  logic [1:0]         wr_canal = '0;
  logic [ANCHO-1:0]   wr_dato = '0;
  logic [CANALES-1:0] clk_div, tick, pendiente;

  int n_cmp = 0;
  int n_err = 0;

  // Expected tick / clk_div on the six edges following the sync in the phase-alignment step.
  localparam logic [2:0] T3_TICK [6] = '{3'b000, 3'b010, 3'b100, 3'b010, 3'b001, 3'b110};
  localparam logic [2:0] T3_CLK  [6] = '{3'b000, 3'b010, 3'b110, 3'b100, 3'b101, 3'b011};

  divisor_reloj_multicanal #(
    .CANALES (CANALES),
    .ANCHO   (ANCHO),
    .DIV_DEF (DIV_DEF)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (en),
    .sync      (sync),
    .wr_en     (wr_en),
`ifdef DIVISOR_DUTY_EN
    .wr_sel    (wr_sel),
`endif
    .wr_canal  (wr_canal),
    .wr_dato   (wr_dato),
    .clk_div   (clk_div),
    .tick      (tick),
    .pendiente (pendiente)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    #1 reset_n = 1'b0;
    #2;
    check("rst_clk_div", 32'(clk_div), 32'd0);
    check("rst_tick", 32'(tick), 32'd0);
    check("rst_pend", 32'(pendiente), 32'd0);
    #9 reset_n = 1'b1;

    // Default divide 4: tick every 5 edges, clk_div period 10
    for (int k = 1; k <= 20; k++) begin
      step(1);
      check("t1_tick0", 32'(tick[0]), 32'((k % 5) == 0));
      check("t1_clk0", 32'(clk_div[0]), 32'(((k / 5) % 2) == 1));
    end

    // Mid-period write to ch1 waits for its wrap
    step(2);
    wr_en = 1'b1; wr_canal = 2'd1; wr_dato = 8'd1;
    step(1);
    wr_en = 1'b0;
    check("t2_pend_set", 32'(pendiente), 32'b010);
    step(1);
    check("t2_pend_hold", 32'(pendiente), 32'b010);
    check("t2_tick_pre", 32'(tick), 32'b000);
    step(1);
    check("t2_pend_clr", 32'(pendiente), 32'b000);
    check("t2_tick_wrap", 32'(tick), 32'b111);
    for (int k = 26; k <= 33; k++) begin
      step(1);
      check("t2_tick1", 32'(tick[1]), 32'((k % 2) == 1));
      check("t2_clk1", 32'(clk_div[1]), 32'((((k - 25) / 2) % 2) == 0));
    end

    // Write ch2 on its wrap edge, then sync three edges later
    step(1);
    wr_en = 1'b1; wr_canal = 2'd2; wr_dato = 8'd2;
    step(1);
    wr_en = 1'b0;
    check("t3_tick2_wrap", 32'(tick[2]), 32'd1);
    check("t3_pend_kept", 32'(pendiente), 32'b100);
    step(2);
    sync = 1'b1;
    step(1);
    sync = 1'b0;
    check("t3_sync_clk", 32'(clk_div), 32'b000);
    check("t3_sync_tick", 32'(tick), 32'b000);
    check("t3_sync_pend", 32'(pendiente), 32'b000);
    for (int k = 0; k < 6; k++) begin
      step(1);
      check("t3_tick", 32'(tick), 32'(T3_TICK[k]));
      check("t3_clk", 32'(clk_div), 32'(T3_CLK[k]));
    end

    // Freeze ch0 for 7 edges with cnt=1 and clk_div high
    en = 3'b110;
    for (int k = 0; k < 7; k++) begin
      step(1);
      check("t4_frz_tick0", 32'(tick[0]), 32'd0);
      check("t4_frz_clk0", 32'(clk_div[0]), 32'd1);
    end
    en = 3'b111;
    for (int k = 0; k < 3; k++) begin
      step(1);
      check("t4_run_tick0", 32'(tick[0]), 32'd0);
    end
    step(1);
    check("t4_resume_tick0", 32'(tick[0]), 32'd1);
    check("t4_resume_clk0", 32'(clk_div[0]), 32'd0);

    // Out-of-range channel write changes nothing
    wr_en = 1'b1; wr_canal = 2'd3; wr_dato = 8'd0;
    step(1);
    wr_en = 1'b0;
    check("t5_oor_pend", 32'(pendiente), 32'b000);
    step(3);
    check("t5_oor_tick0_pre", 32'(tick[0]), 32'd0);
    step(1);
    check("t5_oor_tick0", 32'(tick[0]), 32'd1);
    check("t5_oor_clk0", 32'(clk_div[0]), 32'd1);

    // Asynchronous reset between edges, then restart with default divide
    #3 reset_n = 1'b0;
    #1;
    check("t5_arst_clk", 32'(clk_div), 32'd0);
    check("t5_arst_tick", 32'(tick), 32'd0);
    check("t5_arst_pend", 32'(pendiente), 32'd0);
    #2 reset_n = 1'b1;
    step(4);
    check("t5_rel_tick_pre", 32'(tick), 32'b000);
    check("t5_rel_clk_pre", 32'(clk_div), 32'b000);
    step(1);
    check("t5_rel_tick", 32'(tick), 32'b111);
    check("t5_rel_clk", 32'(clk_div), 32'b111);

`ifdef DIVISOR_DUTY_EN
    // Duty mode: div 9, duty 3 -> high 3 of every 10 edges
    wr_en = 1'b1; wr_canal = 2'd0; wr_sel = 1'b0; wr_dato = 8'd9;
    step(1);
    wr_sel = 1'b1; wr_dato = 8'd3;
    step(1);
    wr_en = 1'b0;
    sync = 1'b1;
    step(1);
    sync = 1'b0;
    for (int k = 1; k <= 29; k++) begin
      step(1);
      check("t6_duty3", 32'(clk_div[0]), 32'((k % 10) < 3));
    end
    wr_en = 1'b1; wr_dato = 8'd0;
    step(1);
    wr_en = 1'b0;
    sync = 1'b1;
    step(1);
    sync = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step(1);
      check("t6_duty0", 32'(clk_div[0]), 32'd0);
    end
    wr_en = 1'b1; wr_dato = 8'd12;
    step(1);
    wr_en = 1'b0;
    sync = 1'b1;
    step(1);
    sync = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step(1);
      check("t6_duty12", 32'(clk_div[0]), 32'd1);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
